// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: pipelined signed adder tree with valid/ready handshake and
// multi-beat group accumulation. One result is produced per first..last group.
// Optional feature: define ADDER_TREE_SAT_EN to saturate the output conversion
// and expose a registered 'sat' flag; otherwise the result wraps.
module adder_tree_pipe #(
  parameter int unsigned CHANNELS   = 128,
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned OUT_WIDTH  = 32,
  parameter int unsigned PIPE_EVERY = 1,
  parameter int unsigned ACC_GUARD  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*IN_WIDTH-1:0] in_data,
  input  logic                         in_first,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic                         err
`ifdef ADDER_TREE_SAT_EN
  ,
  output logic                         sat
`endif
);

  localparam int unsigned LEVELS = $clog2(CHANNELS);
  localparam int unsigned TREE_W = IN_WIDTH + LEVELS;
  localparam int unsigned ACC_W  = TREE_W + ACC_GUARD;

  // Node count at tree level j: repeated ceiling halving of CHANNELS.
  function automatic int unsigned cnt(input int unsigned j);
    return (CHANNELS + (32'd1 << j) - 32'd1) >> j;
  endfunction

  // Global stall: everything advances unless a result is waiting unconsumed.
  logic adv;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  // Per-level node values (sign-extended to TREE_W) and sideband bits.
  logic signed [TREE_W-1:0] lv [LEVELS+1][CHANNELS];
  logic [LEVELS:0]          lv_v;
  logic [LEVELS:0]          lv_f;
  logic [LEVELS:0]          lv_l;

  logic signed [TREE_W-1:0] in_ext [CHANNELS];
  logic signed [TREE_W-1:0] in_q   [CHANNELS];
  logic                     in_v_q;
  logic                     in_f_q;
  logic                     in_l_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_in
    assign in_ext[k] = TREE_W'($signed(in_data[k*IN_WIDTH +: IN_WIDTH]));
    assign lv[0][k]  = in_q[k];
  end
  assign lv_v[0] = in_v_q;
  assign lv_f[0] = in_f_q;
  assign lv_l[0] = in_l_q;

  // Input capture register, decoupling the tree from the multiplier array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q   <= '{default: '0};
      in_v_q <= 1'b0;
      in_f_q <= 1'b0;
      in_l_q <= 1'b0;
    end else if (adv) begin
      in_q   <= in_ext;
      in_v_q <= in_valid;
      in_f_q <= in_first;
      in_l_q <= in_last;
    end
  end

  for (genvar j = 1; j <= LEVELS; j++) begin : g_lvl
    localparam int unsigned NI = cnt(j - 1);
    localparam int unsigned NO = cnt(j);
    logic signed [TREE_W-1:0] s [NO];

    // Pair adjacent nodes; an odd leftover passes through unchanged.
    for (genvar k = 0; k < NO; k++) begin : g_node
      if (2*k + 1 < NI) begin : g_pair
        assign s[k] = lv[j-1][2*k] + lv[j-1][2*k+1];
      end else begin : g_pass
        assign s[k] = lv[j-1][2*k];
      end
    end

    if ((j % PIPE_EVERY == 0) || (j == LEVELS)) begin : g_reg
      logic signed [TREE_W-1:0] q [NO];
      logic                     qv;
      logic                     qf;
      logic                     ql;

      // Pipeline register after this level, carrying valid/first/last along.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q  <= '{default: '0};
          qv <= 1'b0;
          qf <= 1'b0;
          ql <= 1'b0;
        end else if (adv) begin
          q  <= s;
          qv <= lv_v[j-1];
          qf <= lv_f[j-1];
          ql <= lv_l[j-1];
        end
      end

      for (genvar k = 0; k < NO; k++) begin : g_out
        assign lv[j][k] = q[k];
      end
      assign lv_v[j] = qv;
      assign lv_f[j] = qf;
      assign lv_l[j] = ql;
    end else begin : g_comb
      for (genvar k = 0; k < NO; k++) begin : g_out
        assign lv[j][k] = s[k];
      end
      assign lv_v[j] = lv_v[j-1];
      assign lv_f[j] = lv_f[j-1];
      assign lv_l[j] = lv_l[j-1];
    end

    for (genvar k = NO; k < CHANNELS; k++) begin : g_pad
      assign lv[j][k] = '0;
    end
  end

  logic signed [TREE_W-1:0] tree_c;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum_c;
  logic                     grp_open;
  logic [OUT_WIDTH-1:0]     conv_c;

  assign tree_c    = lv[LEVELS][0];
  assign acc_sum_c = lv_f[LEVELS] ? ACC_W'(tree_c) : acc + ACC_W'(tree_c);

`ifdef ADDER_TREE_SAT_EN
  logic sat_c;

  if (ACC_W > OUT_WIDTH) begin : g_sat
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(OUT_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    // Clamp the accumulated sum into the signed OUT_WIDTH range.
    always_comb begin
      conv_c = OUT_WIDTH'(acc_sum_c);
      sat_c  = 1'b0;
      if (acc_sum_c > SAT_MAX) begin
        conv_c = OUT_WIDTH'(SAT_MAX);
        sat_c  = 1'b1;
      end else if (acc_sum_c < SAT_MIN) begin
        conv_c = OUT_WIDTH'(SAT_MIN);
        sat_c  = 1'b1;
      end
    end
  end else begin : g_nosat
    assign conv_c = OUT_WIDTH'(acc_sum_c);
    assign sat_c  = 1'b0;
  end

  // Saturation flag travels with the output data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat <= 1'b0;
    end else if (adv && lv_v[LEVELS] && lv_l[LEVELS]) begin
      sat <= sat_c;
    end
  end
`else
  assign conv_c = OUT_WIDTH'(acc_sum_c);
`endif

  // Group accumulator, framing-error tracking and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      grp_open  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
    end else if (adv) begin
      out_valid <= lv_v[LEVELS] && lv_l[LEVELS];
      if (lv_v[LEVELS]) begin
        // first while open discards a partial; continuation while closed starts from 0
        if (lv_f[LEVELS] == grp_open) begin
          err <= 1'b1;
        end
        if (lv_l[LEVELS]) begin
          out_data <= conv_c;
          acc      <= '0;
          grp_open <= 1'b0;
        end else begin
          acc      <= acc_sum_c;
          grp_open <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed bench for adder_tree_pipe: three instances cover an odd channel
// count, a wide 128-channel multi-beat group, and narrow-output conversion.
module tb_adder_tree_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // CHANNELS=5, IN_WIDTH=8, P=3
  logic        v5, rdy5, f5, l5, ov5, or5, err5;
  logic [39:0] d5;
  logic [31:0] od5;
  // CHANNELS=128, IN_WIDTH=8, PIPE_EVERY=2, P=4
  logic          v128, rdy128, f128, l128, ov128, or128, err128;
  logic [1023:0] d128;
  logic [31:0]   od128;
  // CHANNELS=4, IN_WIDTH=16, OUT_WIDTH=8, P=2
  logic        v8, rdy8, f8, l8, ov8, or8, err8;
  logic [63:0] d8;
  logic [7:0]  od8;
`ifdef ADDER_TREE_SAT_EN
  logic sat5, sat128, sat8;
`endif

  adder_tree_pipe #(.CHANNELS(5), .IN_WIDTH(8), .OUT_WIDTH(32), .PIPE_EVERY(1), .ACC_GUARD(16)) u5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(rdy5), .in_data(d5),
    .in_first(f5), .in_last(l5), .out_valid(ov5), .out_ready(or5), .out_data(od5), .err(err5)
`ifdef ADDER_TREE_SAT_EN
    , .sat(sat5)
`endif
  );

  adder_tree_pipe #(.CHANNELS(128), .IN_WIDTH(8), .OUT_WIDTH(32), .PIPE_EVERY(2), .ACC_GUARD(16)) u128 (
    .clk(clk), .rst_n(rst_n), .in_valid(v128), .in_ready(rdy128), .in_data(d128),
    .in_first(f128), .in_last(l128), .out_valid(ov128), .out_ready(or128), .out_data(od128), .err(err128)
`ifdef ADDER_TREE_SAT_EN
    , .sat(sat128)
`endif
  );

  adder_tree_pipe #(.CHANNELS(4), .IN_WIDTH(16), .OUT_WIDTH(8), .PIPE_EVERY(1), .ACC_GUARD(16)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_data(d8),
    .in_first(f8), .in_last(l8), .out_valid(ov8), .out_ready(or8), .out_data(od8), .err(err8)
`ifdef ADDER_TREE_SAT_EN
    , .sat(sat8)
`endif
  );

  function automatic logic [39:0] pk5(input int a, input int b, input int c, input int e, input int g);
    return {8'(g), 8'(e), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [63:0] pk8(input int a, input int b, input int c, input int e);
    return {16'(e), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int pulses;
  int lat;
  logic signed [63:0] got;

  initial begin
    rst_n = 1'b0;
    v5 = 1'b0; f5 = 1'b0; l5 = 1'b0; d5 = '0; or5 = 1'b1;
    v128 = 1'b0; f128 = 1'b0; l128 = 1'b0; d128 = '0; or128 = 1'b1;
    v8 = 1'b0; f8 = 1'b0; l8 = 1'b0; d8 = '0; or8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_ov5", 64'(ov5), 64'(0));
    check("rst_od5", 64'($signed(od5)), 64'(0));
    check("rst_err5", 64'(err5), 64'(0));
    check("rst_ov128", 64'(ov128), 64'(0));
    rst_n = 1'b1;
    #1;
    check("rst_rdy5", 64'(rdy5), 64'(1));
    check("rst_rdy128", 64'(rdy128), 64'(1));
    tick();

    // Odd channel count, single-beat group, latency P+1 = 4
    d5 = pk5(1, 2, 3, 4, 5); f5 = 1'b1; l5 = 1'b1; v5 = 1'b1;
    tick();
    v5 = 1'b0; f5 = 1'b0; l5 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check("t1_early_ov", 64'(ov5), 64'(0));
    end
    tick();
    check("t1_ov", 64'(ov5), 64'(1));
    check("t1_sum", 64'($signed(od5)), 64'(15));
    tick();
    check("t1_pulse", 64'(ov5), 64'(0));

    // 128 x -128 over a 3-beat group, latency P+1 = 5
    d128 = {128{8'h80}}; v128 = 1'b1; f128 = 1'b1; l128 = 1'b0;
    tick();
    f128 = 1'b0;
    tick();
    l128 = 1'b1;
    tick();
    v128 = 1'b0; l128 = 1'b0;
    pulses = 0; lat = 0; got = '0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (ov128) begin
        pulses++;
        lat = c;
        got = 64'($signed(od128));
      end
    end
    check("t2_pulses", 64'(pulses), 64'(1));
    check("t2_latency", 64'(lat), 64'(5));
    check("t2_sum", got, 64'(-49152));
    check("t2_err", 64'(err128), 64'(0));

    // Back-to-back groups with a 4-cycle output stall
    or5 = 1'b0;
    d5 = pk5(1, 2, 3, 4, 5); v5 = 1'b1; f5 = 1'b1; l5 = 1'b0;
    tick();
    d5 = pk5(1, 1, 1, 1, 1); f5 = 1'b0; l5 = 1'b1;
    tick();
    d5 = pk5(10, 20, 30, 40, -50); f5 = 1'b1; l5 = 1'b1;
    tick();
    v5 = 1'b0; f5 = 1'b0; l5 = 1'b0;
    tick();
    tick();
    check("t3_not_yet", 64'(ov5), 64'(0));
    tick();
    check("t3_ov_a", 64'(ov5), 64'(1));
    check("t3_sum_a", 64'($signed(od5)), 64'(20));
    check("t3_stall_rdy", 64'(rdy5), 64'(0));
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t3_hold_ov", 64'(ov5), 64'(1));
      check("t3_hold_sum", 64'($signed(od5)), 64'(20));
      check("t3_hold_rdy", 64'(rdy5), 64'(0));
    end
    or5 = 1'b1;
    #1;
    check("t3_hs_rdy", 64'(rdy5), 64'(1));
    tick();
    check("t3_ov_b", 64'(ov5), 64'(1));
    check("t3_sum_b", 64'($signed(od5)), 64'(50));
    tick();
    check("t3_done", 64'(ov5), 64'(0));

    // Restarted group: partial discarded, err sticky
    check("t4_err_pre", 64'(err5), 64'(0));
    d5 = pk5(1, 1, 1, 1, 1); v5 = 1'b1; f5 = 1'b1; l5 = 1'b0;
    tick();
    d5 = pk5(2, 2, 2, 2, 2);
    tick();
    d5 = pk5(3, 3, 3, 3, 3); f5 = 1'b0; l5 = 1'b1;
    tick();
    v5 = 1'b0; l5 = 1'b0;
    pulses = 0; lat = 0; got = '0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (ov5) begin
        pulses++;
        lat = c;
        got = 64'($signed(od5));
      end
    end
    check("t4_pulses", 64'(pulses), 64'(1));
    check("t4_latency", 64'(lat), 64'(4));
    check("t4_sum", got, 64'(25));
    check("t4_err", 64'(err5), 64'(1));
    tick();
    check("t4_err_sticky", 64'(err5), 64'(1));

    // Narrow output: overflow positive, overflow negative, in range
    v8 = 1'b1; f8 = 1'b1; l8 = 1'b1;
    d8 = pk8(100, 100, 50, 50);
    tick();
    d8 = pk8(-100, -100, -50, -50);
    tick();
    d8 = pk8(10, 20, 30, 40);
    tick();
    v8 = 1'b0; f8 = 1'b0; l8 = 1'b0;
    tick();
    check("t5_ov_pos", 64'(ov8), 64'(1));
`ifdef ADDER_TREE_SAT_EN
    check("t5_pos", 64'($signed(od8)), 64'(127));
    check("t5_sat_pos", 64'(sat8), 64'(1));
`else
    check("t5_pos", 64'($signed(od8)), 64'(44));
`endif
    tick();
`ifdef ADDER_TREE_SAT_EN
    check("t5_neg", 64'($signed(od8)), 64'(-128));
    check("t5_sat_neg", 64'(sat8), 64'(1));
`else
    check("t5_neg", 64'($signed(od8)), 64'(-44));
`endif
    tick();
    check("t5_mid", 64'($signed(od8)), 64'(100));
`ifdef ADDER_TREE_SAT_EN
    check("t5_sat_mid", 64'(sat8), 64'(0));
`endif
    check("t5_err", 64'(err8), 64'(0));
    tick();
    check("t5_done", 64'(ov8), 64'(0));

    // Reset mid-group, then one clean group
    d5 = pk5(5, 5, 5, 5, 5); v5 = 1'b1; f5 = 1'b1; l5 = 1'b0;
    tick();
    v5 = 1'b0; f5 = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_ov", 64'(ov5), 64'(0));
    check("t6_rst_err", 64'(err5), 64'(0));
    tick();
    rst_n = 1'b1;
    d5 = pk5(1, 1, 1, 1, 1); v5 = 1'b1; f5 = 1'b1; l5 = 1'b0;
    tick();
    d5 = pk5(2, 2, 2, 2, 2); f5 = 1'b0; l5 = 1'b1;
    tick();
    v5 = 1'b0; l5 = 1'b0;
    pulses = 0; lat = 0; got = '0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (ov5) begin
        pulses++;
        lat = c;
        got = 64'($signed(od5));
      end
    end
    check("t6_pulses", 64'(pulses), 64'(1));
    check("t6_latency", 64'(lat), 64'(4));
    check("t6_sum", got, 64'(15));
    check("t6_err", 64'(err5), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_tree_pipe.md
# adder_tree_pipe

Pipelined, parametrised signed adder tree with valid/ready handshake and multi-beat group accumulation. It sums `CHANNELS` signed operands per beat and accumulates successive beats of a group delimited by `in_first`/`in_last`. One result is emitted per group, so a convolution reduction wider than the tree can be folded over several beats. It sits between the per-channel multiplier array and the bias/activation stage of the CNN datapath, and supports any channel count, not only powers of two.

## Interface
- `CHANNELS`, 128, operands per beat; any integer >= 2
- `IN_WIDTH`, 32, signed width of each operand
- `OUT_WIDTH`, 32, signed width of the result
- `PIPE_EVERY`, 1, pipeline register inserted after every `PIPE_EVERY` tree levels (1..LEVELS)
- `ACC_GUARD`, 16, extra accumulator bits beyond full tree growth
- `clk` input 1 — the single clock; all logic is on its rising edge
- `rst_n` input 1 — reset, asynchronous, active-low
- `in_valid` input 1 — beat present
- `in_ready` output 1 — beat accepted when `in_valid && in_ready`
- `in_data` input CHANNELS*IN_WIDTH — operand k at bits [k*IN_WIDTH +: IN_WIDTH]
- `in_first` input 1 — first beat of group
- `in_last` input 1 — last beat of group
- `out_valid` output 1 — result present
- `out_ready` input 1 — result consumed when `out_valid && out_ready`
- `out_data` output OUT_WIDTH — group sum
- `err` output 1 — sticky group-framing error

## Operation
- LEVELS = ceil(log2(CHANNELS)). TREE_W = IN_WIDTH+LEVELS. ACC_W = TREE_W+ACC_GUARD.
- Each level pairs adjacent operands and sign-extends by one bit. An odd leftover operand is passed through unchanged, with sign extension, to the next level.
- A register stage follows level j when j mod PIPE_EVERY == 0, and always after the final level. Registered stage count is P = ceil(LEVELS/PIPE_EVERY).
- `in_first`/`in_last` and a valid bit travel with the data through every register stage.
- The accumulator stage, at the tree output:
  - On a valid beat with first=1: acc <= tree.
  - On a valid beat with first=0: acc <= acc + tree.
  - On a valid beat with last=1: the result is loaded into the output register, `out_valid` is set, and acc is cleared to 0.
- first=1 and last=1 on the same beat is a single-beat group: output = tree sum.
- first=1 while a group is open (acc holds a partial, no last seen): the partial is discarded, a new group starts, and `err` is set.
- first=0 with no group open: the beat accumulates from 0 and `err` is set.
- Output conversion: ACC_W is truncated to the lower OUT_WIDTH bits (two's-complement wrap). The saturation option is described under Configuration.
- Stall is global: `in_ready = !(out_valid && !out_ready)`. While stalled, every pipeline register, the accumulator and the output hold.
- `err` clears only on reset.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `err`=0, all stage valids 0, acc=0, group-open=0, and `in_ready`=1 as soon as reset deasserts.
- Latency: an accepted beat with last=1 at edge n gives `out_valid`=1 after edge n+P+1, when unstalled.
- Throughput: one beat per cycle. Back-to-back groups are allowed with no bubble.
- With `out_ready` held high, `out_valid` is a one-cycle pulse per group.
- When `out_valid` && !`out_ready`: `out_data` is stable and `in_ready`=0 until the handshake completes. The handshake cycle itself has `in_ready`=1, so a new result may load in the same edge.
- Reset asserted mid-group or mid-stall: all state is cleared immediately. Partial groups are lost and no output is produced.

## Configuration
- `ADDER_TREE_SAT_EN` defined: the output conversion saturates. Values above 2^(OUT_WIDTH-1)-1 clamp to that maximum, and values below -2^(OUT_WIDTH-1) clamp to that minimum. An additional output port `sat` (1 bit) is registered with `out_data` and is high when clamping occurred.
- Not defined: wrap truncation applies and no `sat` port exists.

## Test plan
- CHANNELS=5, IN_WIDTH=8, operands {1,2,3,4,5}, first=last=1 -> `out_data`=15 exactly P+1 cycles after acceptance. This covers odd-leftover pass-through.
- CHANNELS=128, all operands -128 (IN_WIDTH=8), 3-beat group -> `out_data`=-49152, one `out_valid` pulse only, after the third beat.
- Stream two groups back-to-back with `out_ready`=0 for 4 cycles after the first result -> `in_ready`=0 during the stall, first result stable, both results correct and in order.
- Send first=1, then first=1 again without last, then last=1 -> output equals only the second group's sum and `err`=1 stays high.
- OUT_WIDTH=8, single beat summing to 300 -> `out_data`=44 without the macro. With `ADDER_TREE_SAT_EN` defined -> `out_data`=127 and `sat`=1.
- Assert `rst_n` low mid-group for 1 cycle, then send one full group -> no spurious output, correct sum of the new group only, `err`=0.
